// File: rtl/block_mem_bridge.sv
// block_mem_bridge: carries one 256-bit block read or write request at a time
// to a single-port 32-bit synchronous RAM as eight back-to-back word beats,
// and assembles read words into a block-wide response.
// Optional feature: define BLOCK_MEM_BRIDGE_WMASK_EN to add a per-word write
// mask (req_wmask). Masked-off write beats keep their cycle but drive no strobe.
module block_mem_bridge #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned WORDS  = 8,
   parameter int unsigned WORD_W = 32
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_write,
   input  logic [ADDR_W-1:0]               req_addr,
   input  logic [WORDS*WORD_W-1:0]         req_wdata,
`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
   input  logic [WORDS-1:0]                req_wmask,
`endif
   output logic                            rsp_valid,
   output logic [WORDS*WORD_W-1:0]         rsp_rdata,
   output logic                            ram_en,
   output logic                            ram_we,
   output logic [ADDR_W+$clog2(WORDS)-1:0] ram_addr,
   output logic [WORD_W-1:0]               ram_wdata,
   input  logic [WORD_W-1:0]               ram_rdata
);

   localparam int unsigned       BEAT_W    = $clog2(WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      RESP
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] prevBeat;
   logic [ADDR_W-1:0] addrQ;
   logic [WORD_W-1:0] wrWords [WORDS];
   logic [WORD_W-1:0] rdWords [WORDS];
   logic              beatOn;

`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
   logic [WORDS-1:0]  wmaskQ;

   // Latch the per-word write mask together with the request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wmaskQ <= '0;
      end else if (state == IDLE && req_valid) begin
         wmaskQ <= req_wmask;
      end
   end

   assign beatOn = wmaskQ[beat];
`else
   assign beatOn = 1'b1;
`endif

   // Read data for beat b-1 arrives while beat b is on the RAM port.
   assign prevBeat = beat - 1'b1;

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state decode and all handshake/RAM outputs, decoded from state.
   always_comb begin
      stateNext = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               stateNext = req_write ? WRITE : READ;
            end
         end
         WRITE: begin
            ram_en    = beatOn;
            ram_we    = beatOn;
            ram_addr  = {addrQ, beat};
            ram_wdata = wrWords[beat];
            if (beat == LAST_BEAT) begin
               stateNext = RESP;
            end
         end
         READ: begin
            ram_en   = 1'b1;
            ram_addr = {addrQ, beat};
            if (beat == LAST_BEAT) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            stateNext = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Request capture and beat counter; beat restarts at 0 on every accept.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         beat  <= '0;
         addrQ <= '0;
         for (int unsigned i = 0; i < WORDS; i++) begin
            wrWords[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               beat <= '0;
               if (req_valid) begin
                  addrQ <= req_addr;
                  for (int unsigned i = 0; i < WORDS; i++) begin
                     wrWords[i] <= req_wdata[i*WORD_W +: WORD_W];
                  end
               end
            end
            WRITE, READ: begin
               beat <= beat + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Read assembly: capture each returning word one cycle behind its beat.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < WORDS; i++) begin
            rdWords[i] <= '0;
         end
      end else if (state == READ && beat != '0) begin
         rdWords[prevBeat] <= ram_rdata;
      end else if (state == DRAIN) begin
         rdWords[LAST_BEAT] <= ram_rdata;
      end
   end

   // Pack the read words into the response bus, word 0 in the low bits.
   always_comb begin
      rsp_rdata = '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
         rsp_rdata[i*WORD_W +: WORD_W] = rdWords[i];
      end
   end

endmodule

// File: tb/tb_block_mem_bridge.sv
// Testbench for block_mem_bridge: a word RAM model on the narrow side, a
// block-level reference memory for expected data, and a scoreboard monitor
// that checks every RAM beat and every response against queued expectations.
module tb_block_mem_bridge;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned WORDS  = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BLK_W  = WORDS * WORD_W;
   localparam int unsigned RA_W   = ADDR_W + 3;
   localparam longint unsigned PERIOD = 10;
   localparam longint unsigned HALF   = 5;

   logic              clock     = 1'b0;
   logic              reset     = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_write = 1'b0;
   logic [ADDR_W-1:0] req_addr  = '0;
   logic [BLK_W-1:0]  req_wdata = '0;
`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
   logic [WORDS-1:0]  req_wmask = '1;
`endif
   logic              req_ready;
   logic              rsp_valid;
   logic [BLK_W-1:0]  rsp_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [RA_W-1:0]   ram_addr;
   logic [WORD_W-1:0] ram_wdata;
   logic [WORD_W-1:0] ram_rdata = '0;

   block_mem_bridge #(
      .ADDR_W(ADDR_W),
      .WORDS (WORDS),
      .WORD_W(WORD_W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
      .req_wmask(req_wmask),
`endif
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clock = ~clock;

   // Single-port synchronous RAM: read data appears the cycle after the strobe.
   logic [WORD_W-1:0] ramMem [1 << RA_W];
   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) ramMem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ramMem[ram_addr];
      end
   end

   // Block-level reference memory and the last block returned by a read.
   logic [BLK_W-1:0] refMem [1 << ADDR_W];
   logic [BLK_W-1:0] lastRead;

   typedef struct {
      longint unsigned t;
      logic [RA_W-1:0]   addr;
      logic              we;
      logic [WORD_W-1:0] wdata;
   } ramExp_t;

   typedef struct {
      longint unsigned t;
      logic [BLK_W-1:0] rdata;
   } rspExp_t;

   ramExp_t ramQ [$];
   rspExp_t rspQ [$];
   int      checks = 0;
   int      errors = 0;

   task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [BLK_W-1:0] randBlock();
      logic [BLK_W-1:0] v;
      for (int unsigned i = 0; i < WORDS; i++) v[i*WORD_W +: WORD_W] = $urandom;
      return v;
   endfunction

   function automatic logic [ADDR_W-1:0] pickAddr();
      case ($urandom_range(0, 6))
         0:       return 11'h000;
         1:       return 11'h001;
         2:       return 11'h005;
         3:       return 11'h033;
         4:       return 11'h400;
         5:       return 11'h7FE;
         default: return 11'h7FF;
      endcase
   endfunction

   // Expected behaviour of one accepted request. Cycle k of an operation is
   // seen at the falling edge (k-1)*PERIOD+HALF after the accept edge t:
   // beat b in cycle b+1, write response in cycle 9, read response in cycle 10.
   task automatic model(input logic wr, input logic [ADDR_W-1:0] addr, input logic [BLK_W-1:0] data,
                        input logic [WORDS-1:0] mask, input longint unsigned t);
      ramExp_t r;
      rspExp_t s;
      for (int unsigned b = 0; b < WORDS; b++) begin
         if (!wr || mask[b]) begin
            r.t     = t + b * PERIOD + HALF;
            r.addr  = RA_W'(int'(addr) * WORDS + b);
            r.we    = wr;
            r.wdata = data[b*WORD_W +: WORD_W];
            ramQ.push_back(r);
            if (wr) refMem[addr][b*WORD_W +: WORD_W] = data[b*WORD_W +: WORD_W];
         end
      end
      if (wr) begin
         s.t     = t + 8 * PERIOD + HALF;
         s.rdata = lastRead;
      end else begin
         s.t      = t + 9 * PERIOD + HALF;
         s.rdata  = refMem[addr];
         lastRead = refMem[addr];
      end
      rspQ.push_back(s);
   endtask

   // Called at a falling edge: present the request and hold it until accepted.
   task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [BLK_W-1:0] data,
                        input logic [WORDS-1:0] mask, output longint unsigned acceptT);
      int unsigned waitCyc = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = data;
`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
      req_wmask = mask;
`endif
      while (req_ready !== 1'b1 && waitCyc < 40) begin
         @(negedge clock);
         waitCyc++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready %b after %0d cycles, required 1", req_ready, waitCyc);
         req_valid = 1'b0;
         acceptT   = 0;
         return;
      end
      acceptT = $time + HALF;
      model(wr, addr, data, mask, acceptT);
      @(posedge clock);
      @(negedge clock);
      check("ready_low_after_accept", req_ready, 1'b0);
      // Scramble the request inputs; the operation in flight must ignore them.
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = ADDR_W'($urandom);
      req_wdata = randBlock();
`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
      req_wmask = WORDS'($urandom);
`endif
   endtask

   // Scoreboard monitor: every RAM strobe and every response must match the
   // oldest queued expectation, at the expected time.
   ramExp_t mRam;
   rspExp_t mRsp;
   always @(negedge clock) begin
      if (ram_en) begin
         if (ramQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ram_unexpected: strobe at addr %h, required no strobe", ram_addr);
         end else begin
            mRam = ramQ.pop_front();
            check("ram_time", $time, mRam.t);
            check("ram_addr", ram_addr, mRam.addr);
            check("ram_we", ram_we, mRam.we);
            if (mRam.we) check("ram_wdata", ram_wdata, mRam.wdata);
         end
      end else begin
         check("ram_we_without_en", ram_we, 1'b0);
      end
      if (rsp_valid) begin
         if (rspQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid 1, required 0");
         end else begin
            mRsp = rspQ.pop_front();
            check("rsp_time", $time, mRsp.t);
            check("rsp_rdata", rsp_rdata, mRsp.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   initial begin
      longint unsigned  tA;
      longint unsigned  tB;
      logic [BLK_W-1:0] pat;
      for (int unsigned i = 0; i < (1 << RA_W); i++) ramMem[i] = '0;
      for (int unsigned i = 0; i < (1 << ADDR_W); i++) refMem[i] = '0;
      lastRead = '0;
      for (int unsigned i = 0; i < WORDS; i++) pat[i*WORD_W +: WORD_W] = 32'h11111111 * (i + 1);

      // Reset with a request already held: outputs must sit at reset values.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 11'h005;
      req_wdata = pat;
      #12;
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_rdata", rsp_rdata, '0);
      check("reset_ram_en", ram_en, 1'b0);
      check("reset_ram_we", ram_we, 1'b0);
      check("reset_ram_addr", ram_addr, '0);
      check("reset_ram_wdata", ram_wdata, '0);

      // Release and accept on the first edge: write 0x005, then read it back.
      @(negedge clock);
      reset = 1'b1;
      issue(1'b1, 11'h005, pat, '1, tA);
      @(negedge clock);
      issue(1'b0, 11'h005, randBlock(), '1, tA);

      // Top block: no address wrap; a request held from cycle 3 waits for cycle 11.
      @(negedge clock);
      issue(1'b1, 11'h7FF, randBlock(), '1, tA);
      @(negedge clock);
      issue(1'b0, 11'h7FF, randBlock(), '1, tA);
      @(negedge clock);
      @(negedge clock);
      issue(1'b0, 11'h005, randBlock(), '1, tB);
      check("busy_hold_accept_time", tB, tA + 11 * PERIOD);

      // Reset pulsed during cycle 4 of a write: outputs drop at once, no response.
      @(negedge clock);
      issue(1'b1, 11'h033, randBlock(), '1, tA);
      @(posedge clock);
      @(posedge clock);
      @(posedge clock);
      #2;
      reset = 1'b0;
      ramQ.delete();
      rspQ.delete();
      lastRead = '0;
      #1;
      check("midreset_ram_en", ram_en, 1'b0);
      check("midreset_ram_we", ram_we, 1'b0);
      check("midreset_ram_addr", ram_addr, '0);
      check("midreset_ram_wdata", ram_wdata, '0);
      check("midreset_req_ready", req_ready, 1'b1);
      check("midreset_rsp_valid", rsp_valid, 1'b0);
      check("midreset_rsp_rdata", rsp_rdata, '0);
      @(negedge clock);
      reset = 1'b1;
      issue(1'b1, 11'h033, randBlock(), '1, tA);
      @(negedge clock);
      issue(1'b0, 11'h033, randBlock(), '1, tA);

`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
      // Masked writes: only beats 0, 2, 5, 7 strobe; an empty mask still responds.
      @(negedge clock);
      issue(1'b1, 11'h0AA, randBlock(), '1, tA);
      @(negedge clock);
      issue(1'b1, 11'h0AA, pat, 8'b10100101, tA);
      @(negedge clock);
      issue(1'b0, 11'h0AA, randBlock(), '1, tA);
      @(negedge clock);
      issue(1'b1, 11'h0AA, randBlock(), '0, tA);
      @(negedge clock);
      issue(1'b0, 11'h0AA, randBlock(), '1, tA);
`endif

      // Randomized traffic over a small address pool so reads hit written data.
      for (int unsigned n = 0; n < 60; n++) begin
         logic [WORDS-1:0] m;
         m = '1;
`ifdef BLOCK_MEM_BRIDGE_WMASK_EN
         m = WORDS'($urandom);
`endif
         repeat ($urandom_range(0, 3)) @(negedge clock);
         @(negedge clock);
         issue(1'($urandom_range(0, 1)), pickAddr(), randBlock(), m, tA);
      end

      for (int unsigned i = 0; i < 100 && (ramQ.size() != 0 || rspQ.size() != 0); i++) @(negedge clock);
      if (ramQ.size() != 0 || rspQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d ram beats and %0d responses pending, required 0", ramQ.size(), rspQ.size());
      end
      repeat (5) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
